// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Wide enough to hold the terminal value BURST_MAX itself.
    function automatic int beat_cnt_w(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write-port signals shared by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int Data_Width = 8
);
    localparam int GID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*Data_Width-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        full;
    logic                        wr_en;
    logic [Data_Width-1:0]       data_in;
    logic [GID_W-1:0]            grant_id;
    logic                        busy;

    modport master (
        input  req_valid, req_data, full,
        output req_ready, wr_en, data_in, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, full,
        input  req_ready, wr_en, data_in, grant_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any_req
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for the async FIFO write port.
// Optional per-requester saturating beat counters under `WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int Data_Width = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                    wr_clk,
    input  logic                    wr_rstn,
    fifo_wr_arbiter_if.master       bus
`ifdef WR_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_beats
`endif
);

    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = beat_cnt_w(BURST_MAX);

    arb_state_t       r_state,    w_state_nxt;
    logic [GID_W-1:0] r_rr_ptr,   w_rr_ptr_nxt;
    logic [GID_W-1:0] r_grant_id, w_grant_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

    logic [GID_W-1:0]      w_pick_id;
    logic                  w_any_req;
    logic                  w_g_valid;
    logic [Data_Width-1:0] w_g_data;
    logic [N_REQ-1:0]      w_g_onehot;
    logic [GID_W-1:0]      w_ptr_inc;
    logic                  w_accept;
    logic                  w_wr_en;
    logic [N_REQ-1:0]      w_req_ready;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (GID_W)
    ) u_rr_pick (
        .i_req     (bus.req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_pick_id),
        .o_any_req (w_any_req)
    );

    always_comb begin
        w_g_valid  = bus.req_valid[0];
        w_g_data   = bus.req_data[Data_Width-1:0];
        w_g_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_g_valid     = bus.req_valid[i];
                w_g_data      = bus.req_data[i*Data_Width +: Data_Width];
                w_g_onehot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_inc = (r_grant_id == GID_W'(N_REQ - 1)) ? '0 : r_grant_id + GID_W'(1);

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // full gates the strobe in the same cycle, so a stalled grantee keeps its slot.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_nxt    = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_accept       = 1'b0;
        w_wr_en        = 1'b0;
        w_req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt    = w_pick_id;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = BURST;
                end
            end
            BURST: begin
                w_req_ready = bus.full ? '0 : w_g_onehot;
                w_accept    = w_g_valid & ~bus.full;
                w_wr_en     = w_accept;
                if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    if (r_beat_cnt == CNT_W'(BURST_MAX - 1)) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_ptr_inc;
                    end
                end else if (!bus.full) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_ptr_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready = w_req_ready;
    assign bus.wr_en     = w_wr_en;
    assign bus.data_in   = w_g_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state == BURST);

`ifdef WR_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [N_REQ];

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && (r_grant_id == GID_W'(i)) && (r_stat[i] != '1)) begin
                    r_stat[i] <= r_stat[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
        assign stat_beats[gi*STAT_W +: STAT_W] = r_stat[gi];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin, stalls, early release, stats.
module tb_fifo_wr_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    fifo_wr_arbiter_if #(.N_REQ(4), .Data_Width(8)) bus ();

`ifdef WR_ARB_STATS_EN
    logic [63:0] stat;
`endif

    fifo_wr_arbiter #(
        .N_REQ      (4),
        .Data_Width (8),
        .BURST_MAX  (4)
    ) dut (
        .wr_clk  (clk),
        .wr_rstn (rstn),
        .bus     (bus)
`ifdef WR_ARB_STATS_EN
        ,
        .stat_beats (stat)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic b, input logic w,
                              input logic [1:0] g, input logic [3:0] rdy);
        chk({tag, ".busy"},  32'(bus.busy),      32'(b));
        chk({tag, ".wr_en"}, 32'(bus.wr_en),     32'(w));
        chk({tag, ".gid"},   32'(bus.grant_id),  32'(g));
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
        chk({tag, ".data"},  32'(bus.data_in),   32'(8'hA0 | {6'd0, g}));
    endtask

    task automatic cyc(input string tag, input logic b, input logic w,
                       input logic [1:0] g, input logic [3:0] rdy);
        @(negedge clk);
        check_outs(tag, b, w, g, rdy);
        tick();
    endtask

    initial begin
        logic       b, w, f;
        logic [1:0] g;
        logic [3:0] rdy;

        bus.req_valid = '0;
        bus.full      = 1'b0;
        bus.req_data  = 32'hA3A2A1A0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 2'd0, 4'b0000);
        tick();

        // All four requesting: grants 0,1,2,3,0 with one idle slot between bursts.
        rstn = 1'b1;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 25; c++) begin
            b   = (c % 5) != 0;
            g   = b ? 2'((c / 5) % 4) : ((c == 0) ? 2'd0 : 2'((c / 5 - 1) % 4));
            rdy = b ? 4'(1 << g) : 4'b0000;
            cyc("rr", b, b, g, rdy);
        end
        cyc("rr_wrap_idle", 1'b0, 1'b0, 2'd0, 4'b0000);
        cyc("rr_g1",        1'b1, 1'b1, 2'd1, 4'b0010);

        // Reset asserted in the middle of grantee 1's burst.
        rstn = 1'b0;
        #1;
        check_outs("rst_mid", 1'b0, 1'b0, 2'd0, 4'b0000);
        tick();
        rstn = 1'b1;
        bus.req_valid = '0;
        cyc("rst_rel", 1'b0, 1'b0, 2'd0, 4'b0000);

        // Requester 2 alone: 4 writes, 1 idle, repeating.
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            b = (c % 5) != 0;
            g = (c == 0) ? 2'd0 : 2'd2;
            cyc("single", b, b, g, b ? 4'b0100 : 4'b0000);
        end
        bus.req_valid = '0;
        cyc("single_end", 1'b0, 1'b0, 2'd2, 4'b0000);

        // Grantee 1: 2 beats, full for 3 cycles (withdraws in the middle), 2 more beats.
        for (int c = 0; c < 9; c++) begin
            f = (c >= 3) && (c <= 5);
            bus.full      = f;
            bus.req_valid = ((c == 4) || (c == 8)) ? 4'b0000 : 4'b0010;
            b   = (c >= 1) && (c <= 7);
            w   = (c == 1) || (c == 2) || (c == 6) || (c == 7);
            g   = (c == 0) ? 2'd2 : 2'd1;
            rdy = (b && !f) ? 4'b0010 : 4'b0000;
            cyc("stall", b, w, g, rdy);
        end

        // Grantee 0 drops after one beat; requester 3 takes over after one idle cycle.
        bus.req_valid = 4'b0001;
        cyc("early_arb",  1'b0, 1'b0, 2'd1, 4'b0000);
        cyc("early_b1",   1'b1, 1'b1, 2'd0, 4'b0001);
        bus.req_valid = 4'b1000;
        cyc("early_drop", 1'b1, 1'b0, 2'd0, 4'b0001);
        cyc("early_idle", 1'b0, 1'b0, 2'd0, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            cyc("early_g3", 1'b1, 1'b1, 2'd3, 4'b1000);
        end

        // Departing grantee 3 loses to requester 1 on the next arbitration.
        bus.req_valid = 4'b1010;
        cyc("prio_idle",  1'b0, 1'b0, 2'd3, 4'b0000);
        cyc("prio_g1",    1'b1, 1'b1, 2'd1, 4'b0010);
        bus.req_valid = '0;
        cyc("drop_g1",    1'b1, 1'b0, 2'd1, 4'b0010);
        cyc("final_idle", 1'b0, 1'b0, 2'd1, 4'b0000);

`ifdef WR_ARB_STATS_EN
        begin
            int beats;
            beats = 0;
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
            bus.req_valid = 4'b0001;
            for (int k = 0; (k < 90000) && (beats < 70000); k++) begin
                @(negedge clk);
                if (bus.wr_en) beats++;
            end
            chk("stat_beats_seen", 32'(beats), 32'd70000);
            chk("stat0_sat",       32'(stat[15:0]), 32'h0000FFFF);
            chk("stat1",           32'(stat[31:16]), 32'd0);
            chk("stat2",           32'(stat[47:32]), 32'd0);
            chk("stat3",           32'(stat[63:48]), 32'd0);
            bus.req_valid = '0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
